// File: rtl/net_pkg.sv
// Shared types and default sizing for the row requantize/pack block.
package net_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PROC = 1'b1
    } state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_D     = 8;
    localparam int DEF_SHIFT = 8;

endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: round-half-up shift, optional ReLU, saturate to W bits.
module requant_lane
    import net_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int RELU  = 1
) (
    input  logic signed [2*W-1:0] d,
    output logic signed [W-1:0]   q,
    output logic                  sat
);
    localparam int XW = 2*W + 1;
    localparam int RS = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [XW-1:0] ONE  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] RND  = (SHIFT == 0) ? '0 : (ONE <<< RS);
    localparam logic signed [XW-1:0] QMAX = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] QMIN = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] rnd_sh;
    logic signed [XW-1:0] clip_in;

    // One extra bit keeps the rounding add from overflowing at the input extremes.
    always_comb begin
        ext     = {d[2*W-1], d};
        rnd_sh  = (ext + RND) >>> SHIFT;
        clip_in = ((RELU != 0) && (rnd_sh < 0)) ? '0 : rnd_sh;
        sat     = 1'b0;
        q       = clip_in[W-1:0];
        if (clip_in > QMAX) begin
            q   = QMAX[W-1:0];
            sat = 1'b1;
        end else if (clip_in < QMIN) begin
            q   = QMIN[W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/row_requantize_pack.sv
// Captures one row of eight wide column results, requantizes them one lane per cycle
// through a single shared lane datapath, and publishes the packed row.
module row_requantize_pack
    import net_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int D     = DEF_D,
    parameter int SHIFT = DEF_SHIFT,
    parameter int RELU  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [2*W-1:0] in_d0,
    input  logic signed [2*W-1:0] in_d1,
    input  logic signed [2*W-1:0] in_d2,
    input  logic signed [2*W-1:0] in_d3,
    input  logic signed [2*W-1:0] in_d4,
    input  logic signed [2*W-1:0] in_d5,
    input  logic signed [2*W-1:0] in_d6,
    input  logic signed [2*W-1:0] in_d7,
    input  logic                  in_v,
    output logic signed [D*W-1:0] packed_out,
    output logic                  out_v,
    output logic                  busy,
    output logic                  dropped,
    output logic                  sat
);
    state_t                state, state_nxt;
    logic [2:0]            cnt;
    logic [D-1:0][2*W-1:0] hold;
    logic [D-1:0][W-1:0]   stage, stage_nxt;
    logic signed [W-1:0]   lane_q;
    logic                  lane_sat;
    logic                  last_lane;

    assign last_lane = (cnt == 3'(D-1));
    assign busy      = (state == PROC);

    requant_lane #(
        .W    (W),
        .SHIFT(SHIFT),
        .RELU (RELU)
    ) u_lane (
        .d  (hold[cnt]),
        .q  (lane_q),
        .sat(lane_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_v)      state_nxt = PROC;
            PROC: if (last_lane) state_nxt = IDLE;
        endcase
    end

    // Staging with the current lane merged in, so the last lane lands in packed_out directly.
    always_comb begin
        stage_nxt      = stage;
        stage_nxt[cnt] = lane_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            hold       <= '0;
            stage      <= '0;
            packed_out <= '0;
            out_v      <= 1'b0;
            dropped    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            out_v <= 1'b0;
            if (state == IDLE && in_v) begin
                hold[0] <= in_d0;
                hold[1] <= in_d1;
                hold[2] <= in_d2;
                hold[3] <= in_d3;
                hold[4] <= in_d4;
                hold[5] <= in_d5;
                hold[6] <= in_d6;
                hold[7] <= in_d7;
                cnt     <= '0;
            end
            if (state == PROC) begin
                stage <= stage_nxt;
                cnt   <= cnt + 3'd1;
                if (lane_sat) sat     <= 1'b1;
                if (in_v)     dropped <= 1'b1;
                if (last_lane) begin
                    packed_out <= stage_nxt;
                    out_v      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_row_requantize_pack.sv
// Randomized and directed bench for row_requantize_pack, RELU=1 and RELU=0 side by side.
module tb_row_requantize_pack;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_v = 1'b0;
    logic signed [31:0] d [8];
    logic [127:0]       po1, po0;
    logic               ov1, ov0, bz1, bz0, dr1, dr0, st1, st0;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    row_requantize_pack #(.W(16), .D(8), .SHIFT(8), .RELU(1)) u_r1 (
        .clk(clk), .rst(rst),
        .in_d0(d[0]), .in_d1(d[1]), .in_d2(d[2]), .in_d3(d[3]),
        .in_d4(d[4]), .in_d5(d[5]), .in_d6(d[6]), .in_d7(d[7]),
        .in_v(in_v), .packed_out(po1), .out_v(ov1), .busy(bz1),
        .dropped(dr1), .sat(st1)
    );

    row_requantize_pack #(.W(16), .D(8), .SHIFT(8), .RELU(0)) u_r0 (
        .clk(clk), .rst(rst),
        .in_d0(d[0]), .in_d1(d[1]), .in_d2(d[2]), .in_d3(d[3]),
        .in_d4(d[4]), .in_d5(d[5]), .in_d6(d[6]), .in_d7(d[7]),
        .in_v(in_v), .packed_out(po0), .out_v(ov0), .busy(bz0),
        .dropped(dr0), .sat(st0)
    );

    // Reference arithmetic: floor((x + 2^7) / 2^8), optional ReLU, clamp to int16.
    function automatic longint rq_raw(input longint x, input bit relu);
        longint v;
        v = (x + 64'sd128) >>> 8;
        if (relu && v < 0) v = 0;
        return v;
    endfunction

    function automatic logic [15:0] rq(input longint x, input bit relu);
        longint v;
        v = rq_raw(x, relu);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic bit rq_sat(input longint x, input bit relu);
        longint v;
        v = rq_raw(x, relu);
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a row accepted at edge c completes at c+8, engine free at c+9.
    int           cyc, idle_at, due, sat1_at, sat0_at;
    logic [127:0] row1, row0, m_out1, m_out0;
    logic         m_outv, m_busy, m_drop, m_sat1, m_sat0;

    task automatic m_reset();
        cyc = 0; idle_at = 0; due = -1; sat1_at = -1; sat0_at = -1;
        row1 = '0; row0 = '0; m_out1 = '0; m_out0 = '0;
        m_outv = 0; m_busy = 0; m_drop = 0; m_sat1 = 0; m_sat0 = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else begin
                cyc++;
                m_outv = 0;
                if (cyc == sat1_at) m_sat1 = 1;
                if (cyc == sat0_at) m_sat0 = 1;
                if (cyc == due) begin
                    m_out1 = row1;
                    m_out0 = row0;
                    m_outv = 1;
                end
                if (in_v) begin
                    if (cyc >= idle_at) begin
                        sat1_at = -1;
                        sat0_at = -1;
                        for (int i = 0; i < 8; i++) begin
                            row1[i*16 +: 16] = rq(d[i], 1'b1);
                            row0[i*16 +: 16] = rq(d[i], 1'b0);
                            if (rq_sat(d[i], 1'b1) && sat1_at < 0) sat1_at = cyc + 1 + i;
                            if (rq_sat(d[i], 1'b0) && sat0_at < 0) sat0_at = cyc + 1 + i;
                        end
                        due     = cyc + 8;
                        idle_at = cyc + 9;
                    end else begin
                        m_drop = 1;
                    end
                end
                m_busy = (cyc < idle_at - 1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("out_v_relu1",   ov1, m_outv);
                chk("out_v_relu0",   ov0, m_outv);
                chk("busy_relu1",    bz1, m_busy);
                chk("busy_relu0",    bz0, m_busy);
                chk("packed_relu1",  po1, m_out1);
                chk("packed_relu0",  po0, m_out0);
                chk("dropped_relu1", dr1, m_drop);
                chk("dropped_relu0", dr0, m_drop);
                chk("sat_relu1",     st1, m_sat1);
                chk("sat_relu0",     st0, m_sat0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_d();
        for (int i = 0; i < 8; i++) d[i] = '0;
    endtask

    // Pulse in_v for one edge and count edges until out_v is seen (accept edge counts as 1).
    task automatic send_and_wait(output int n);
        in_v = 1'b1;
        step();
        in_v = 1'b0;
        n = 1;
        while (!ov1 && n < 30) begin
            step();
            n++;
        end
        if (!ov1) begin
            checks++;
            failures++;
            $display("FAIL out_v_timeout actual=none required=pulse");
        end
    endtask

    function automatic int rand_val();
        int m;
        m = int'($urandom_range(0, 3));
        case (m)
            0:       return int'($urandom_range(0, 8000)) - 4000;
            1:       return int'($urandom);
            2:       return (int'($urandom_range(0, 200)) - 100) * 256 + 127 + int'($urandom_range(0, 1));
            default: return 0;
        endcase
    endfunction

    initial begin
        int n, pulses, p1, p2;
        clear_d();
        repeat (3) step();
        checking = 1'b1;
        chk("reset_packed", po1, 128'h0);
        chk("reset_flags", {ov1, bz1, dr1, st1}, 4'b0000);
        rst = 1'b1;
        step();

        chk("pin_384",  rq(384, 1'b1),          16'h0002);
        chk("pin_m384", rq(-384, 1'b0),         16'hFFFF);
        chk("pin_128",  rq(128, 1'b0),          16'h0001);
        chk("pin_m128", rq(-128, 1'b0),         16'h0000);
        chk("pin_max",  rq(32'sh7FFFFFFF, 1'b0), 16'h7FFF);
        chk("pin_min",  rq(-64'sd2147483648, 1'b0), 16'h8000);

        clear_d();
        d[0] = 384;
        send_and_wait(n);
        chk("latency_edges", n, 9);
        chk("row_384_relu1", po1, 128'h2);
        chk("row_384_sat", st1, 1'b0);
        step();

        clear_d();
        d[1] = -384; d[2] = 128; d[3] = -128;
        send_and_wait(n);
        chk("row_round_relu0", po0, 128'h0000_0000_0000_0000_0000_0001_FFFF_0000);
        chk("row_round_relu1", po1, 128'h0000_0000_0000_0000_0000_0001_0000_0000);
        step();

        clear_d();
        d[4] = 32'sh7FFFFFFF; d[5] = 32'sh80000000;
        send_and_wait(n);
        chk("row_sat_relu0", po0, 128'h0000_0000_8000_7FFF_0000_0000_0000_0000);
        chk("row_sat_relu1", po1, 128'h0000_0000_0000_7FFF_0000_0000_0000_0000);
        step();
        chk("sat_sticky", {st1, st0}, 2'b11);
        chk("dropped_before", dr1, 1'b0);

        clear_d();
        d[0] = 1000;
        in_v = 1'b1; step(); in_v = 1'b0;
        step(); step();
        d[0] = 5000;
        in_v = 1'b1; step(); in_v = 1'b0;
        pulses = 0;
        repeat (20) begin
            step();
            if (ov1) pulses++;
        end
        chk("drop_pulses", pulses, 1);
        chk("drop_keeps_first", po1, 128'h4);
        chk("dropped_set", {dr1, dr0}, 2'b11);

        clear_d();
        d[0] = 768;
        pulses = 0; p1 = 0; p2 = 0;
        in_v = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (ov1) begin
                pulses++;
                if (pulses == 1) p1 = s;
                if (pulses == 2) p2 = s;
            end
        end
        in_v = 1'b0;
        repeat (12) step();
        chk("hold_pulses", pulses, 2);
        chk("hold_first",  p1, 9);
        chk("hold_second", p2, 18);
        chk("hold_value",  po1, 128'h3);

        clear_d();
        d[0] = 1000;
        in_v = 1'b1; step(); in_v = 1'b0;
        repeat (3) step();
        @(posedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_packed", {po1, po0}, 256'h0);
        chk("midreset_flags", {ov1, ov0, bz1, bz0, dr1, dr0, st1, st0}, 8'h00);
        step(); step();
        rst = 1'b1;
        pulses = 0;
        repeat (15) begin
            step();
            if (ov1 || ov0) pulses++;
        end
        chk("midreset_no_pulse", pulses, 0);
        clear_d();
        d[0] = -640; d[6] = 1000;
        send_and_wait(n);
        chk("after_reset_relu0", po0, 128'h0000_0004_0000_0000_0000_0000_0000_FFFE);
        chk("after_reset_relu1", po1, 128'h0000_0004_0000_0000_0000_0000_0000_0000);
        step();

        for (int c = 0; c < 600; c++) begin
            in_v = ($urandom_range(0, 99) < 40);
            for (int i = 0; i < 8; i++) d[i] = rand_val();
            step();
        end
        in_v = 1'b0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
